// File: rtl/prime_scan_ctrl_pkg.sv
// Shared definitions for the prime scan sequencer.
//   scan_state_t : sequencer states, also exported on the debug state port
//   WIDTH_DEF    : default width of N, candidate, count and last-prime values
//   TIMEOUT_DEF  : default response watchdog limit in cycles
package prime_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } scan_state_t;

endpackage

// File: rtl/prime_scan_ctrl_if.sv
// Request/response link between the scan sequencer and the prime-test core.
//
// Handshake: the sequencer raises req_o with cand_o and holds both stable
// until a cycle in which ready_i is also 1; that cycle is the transfer.
// req_o never drops without a transfer except on abort. The core answers
// each accepted candidate with exactly one single-cycle resp_valid_i pulse,
// carrying resp_prime_i in the same cycle. There is no back-pressure on the
// response path.
//
//   req_o        sequencer -> core  candidate request (valid)
//   cand_o       sequencer -> core  candidate value
//   ready_i      core -> sequencer  core can accept a request
//   resp_valid_i core -> sequencer  result valid pulse
//   resp_prime_i core -> sequencer  1 = candidate is prime
interface prime_scan_ctrl_if #(
  parameter int WIDTH = prime_pkg::WIDTH_DEF
);

  logic             req_o;
  logic [WIDTH-1:0] cand_o;
  logic             ready_i;
  logic             resp_valid_i;
  logic             resp_prime_i;

  modport master (
    output req_o,
    output cand_o,
    input  ready_i,
    input  resp_valid_i,
    input  resp_prime_i
  );

  modport slave (
    input  req_o,
    input  cand_o,
    output ready_i,
    output resp_valid_i,
    output resp_prime_i
  );

endinterface

// File: rtl/prime_scan_ctrl_watchdog.sv
// Response watchdog: cycle counter with synchronous clear and count enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : restart the count from zero (wins over en_i)
//   en_i       : count one more waiting cycle
//   expired_o  : high in the TIMEOUT-th enabled cycle since the last clear,
//                so the owner can leave its wait state on that edge
module prime_watchdog #(
  parameter int TIMEOUT = prime_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Saturates at LAST so a long-running enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/prime_scan_ctrl.sv
// Scan sequencer: walks candidates 2..N through the shared prime-test core,
// counting primes and remembering the largest one found.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start_i        : start pulse, latches limit_i as N (ignored mid-scan)
//   abort_i        : cancel and clear everything, beats start_i
//   limit_i        : inclusive upper bound N
//   core           : request/response link to the prime-test core
//   busy_o         : scan in progress (ISSUE/WAIT/NEXT)
//   done_o         : scan finished, level until next start/abort
//   err_o          : core response watchdog expired, level
//   count_o        : primes found so far
//   last_prime_o   : largest prime found, 0 if none
//   state_o        : current sequencer state for observation
module prime_scan_ctrl
  import prime_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [WIDTH-1:0]      limit_i,
  prime_scan_ctrl_if.master     core,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [WIDTH-1:0]      count_o,
  output logic [WIDTH-1:0]      last_prime_o,
  output scan_state_t           state_o
);

  scan_state_t      state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             wd_clear, wd_en, wd_expired;

  // Watchdog restarts on every accepted request and counts only the WAIT
  // cycles that carry no response.
  assign wd_clear = abort_i || ((state_q == ST_ISSUE) && core.ready_i);
  assign wd_en    = !abort_i && (state_q == ST_WAIT) && !core.resp_valid_i;

  prime_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (wd_clear),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      cand_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cand_q  <= cand_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cand_d  = cand_q;
    count_d = count_q;
    last_d  = last_q;

    if (abort_i) begin
      state_d = ST_IDLE;
      cand_d  = '0;
      count_d = '0;
      last_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            n_d     = limit_i;
            count_d = '0;
            last_d  = '0;
            if (limit_i < WIDTH'(2)) begin
              cand_d  = '0;
              state_d = ST_DONE;
            end else begin
              cand_d  = WIDTH'(2);
              state_d = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (core.ready_i) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response arriving in the expiry cycle still counts.
          if (core.resp_valid_i) begin
            if (core.resp_prime_i) begin
              count_d = count_q + WIDTH'(1);
              last_d  = cand_q;
            end
            state_d = ST_NEXT;
          end else if (wd_expired) begin
            state_d = ST_ERR;
          end
        end
        ST_NEXT: begin
          // Compare before incrementing so N = all-ones ends without wrap.
          if (cand_q == n_q) begin
            state_d = ST_DONE;
          end else begin
            cand_d  = cand_q + WIDTH'(1);
            state_d = ST_ISSUE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign core.req_o  = (state_q == ST_ISSUE);
  assign core.cand_o = cand_q;
  assign busy_o      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                       (state_q == ST_NEXT);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_ERR);
  assign count_o     = count_q;
  assign last_prime_o = last_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_prime_scan_ctrl.sv
module tb_prime_scan_ctrl;
  import prime_pkg::*;

  localparam int W  = 4;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [W-1:0] limit_i = '0;
  logic         busy_o, done_o, err_o;
  logic [W-1:0] count_o, last_prime_o;
  scan_state_t  state_o;

  always #5 clk = ~clk;

  prime_scan_ctrl_if #(.WIDTH(W)) core ();

  prime_scan_ctrl #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .limit_i      (limit_i),
    .core         (core.master),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .count_o      (count_o),
    .last_prime_o (last_prime_o),
    .state_o      (state_o)
  );

  // ---------------- core model ----------------
  // Accepts on req&ready, answers one cycle later unless the candidate is
  // the one chosen to be dropped. Can also emit one stray response.
  bit           drop_en = 1'b0;
  logic [W-1:0] drop_cand = '0;
  int           stray_req = 0;
  int           stray_done = 0;
  bit           pend = 1'b0;
  logic [W-1:0] pc = '0;
  int           hs_count = 0;
  logic [W-1:0] hs_log [0:63];

  function automatic bit is_prime(input logic [W-1:0] v);
    int x;
    x = int'(v);
    if (x < 2) return 1'b0;
    for (int d = 2; d * d <= x; d++) if (x % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    core.resp_valid_i = 1'b0;
    core.resp_prime_i = 1'b0;
    forever begin
      @(negedge clk);
      core.resp_valid_i = 1'b0;
      core.resp_prime_i = 1'b0;
      if (pend) begin
        if (!(drop_en && pc == drop_cand)) begin
          core.resp_valid_i = 1'b1;
          core.resp_prime_i = is_prime(pc);
        end
        pend = 1'b0;
      end else if (stray_req != stray_done) begin
        stray_done = stray_req;
        core.resp_valid_i = 1'b1;
        core.resp_prime_i = 1'b1;
      end
      if (core.req_o && core.ready_i) begin
        pend = 1'b1;
        pc   = core.cand_o;
        hs_log[hs_count % 64] = pc;
        hs_count++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [W-1:0] lim);
    limit_i = lim;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n;
    n = 0;
    while (!(done_o || err_o) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done_o || err_o), 32'd1);
  endtask

  task automatic wait_state(input scan_state_t st, input logic [W-1:0] c,
                            input int budget, input string tag);
    int n;
    n = 0;
    while (!(state_o == st && core.cand_o == c) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(state_o == st && core.cand_o == c), 32'd1);
  endtask

  // Compare the handshakes logged since 'base' against exp_q.
  task automatic check_log(input int base, input string tag);
    check({tag, "_hs_cnt"}, 32'(hs_count - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < hs_count - base; i++)
      check({tag, "_hs_cand"}, 32'(hs_log[(base + i) % 64]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    core.ready_i = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_req", 32'(core.req_o), 32'd0);
    check("rst_cand", 32'(core.cand_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_last", 32'(last_prime_o), 32'd0);
    check("rst_state", 32'(state_o), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // N = 10, ideal core
    base = hs_count;
    start_scan(4'd10);
    check("n10_req_t1", 32'(core.req_o), 32'd1);
    check("n10_cand_t1", 32'(core.cand_o), 32'd2);
    check("n10_busy", 32'(busy_o), 32'd1);
    wait_end(60, "n10_end");
    check("n10_done", 32'(done_o), 32'd1);
    check("n10_busy_end", 32'(busy_o), 32'd0);
    check("n10_err", 32'(err_o), 32'd0);
    check("n10_count", 32'(count_o), 32'd4);
    check("n10_last", 32'(last_prime_o), 32'd7);
    for (int c = 2; c <= 10; c++) exp_q.push_back(W'(c));
    check_log(base, "n10");

    // N = 1 and N = 0: no requests, done next cycle
    for (int k = 1; k >= 0; k--) begin
      base = hs_count;
      start_scan(W'(k));
      check("small_done_t1", 32'(done_o), 32'd1);
      check("small_req", 32'(core.req_o), 32'd0);
      check("small_count", 32'(count_o), 32'd0);
      check("small_last", 32'(last_prime_o), 32'd0);
      tick();
      tick();
      check("small_no_hs", 32'(hs_count - base), 32'd0);
      check("small_done_hold", 32'(done_o), 32'd1);
    end

    // N = 15: full range, no wrap
    base = hs_count;
    start_scan(4'd15);
    wait_end(80, "n15_end");
    check("n15_done", 32'(done_o), 32'd1);
    check("n15_count", 32'(count_o), 32'd6);
    check("n15_last", 32'(last_prime_o), 32'd13);
    for (int c = 2; c <= 15; c++) exp_q.push_back(W'(c));
    check_log(base, "n15");

    // N = 5 with ready stalled 5 cycles on cand 3, and an ignored start
    base = hs_count;
    start_scan(4'd5);
    wait_state(ST_NEXT, 4'd2, 20, "stall_reach");
    core.ready_i = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_req", 32'(core.req_o), 32'd1);
      check("stall_cand", 32'(core.cand_o), 32'd3);
      start_i = (i == 2);
      limit_i = 4'd15;
      tick();
    end
    start_i = 1'b0;
    core.ready_i = 1'b1;
    wait_end(40, "stall_end");
    check("stall_done", 32'(done_o), 32'd1);
    check("stall_count", 32'(count_o), 32'd3);
    check("stall_last", 32'(last_prime_o), 32'd5);
    for (int c = 2; c <= 5; c++) exp_q.push_back(W'(c));
    check_log(base, "stall");

    // N = 6, core never answers cand 4: watchdog
    drop_en = 1'b1;
    drop_cand = 4'd4;
    start_scan(4'd6);
    wait_state(ST_WAIT, 4'd4, 30, "to_reach");
    for (int k = 1; k <= TO; k++) begin
      tick();
      check("to_err_timing", 32'(err_o), 32'(k == TO));
    end
    check("to_state", 32'(state_o), 32'(ST_ERR));
    check("to_busy", 32'(busy_o), 32'd0);
    check("to_done", 32'(done_o), 32'd0);
    check("to_req", 32'(core.req_o), 32'd0);
    check("to_count", 32'(count_o), 32'd2);
    check("to_last", 32'(last_prime_o), 32'd3);
    stray_req++;
    tick();
    tick();
    tick();
    check("stray_count", 32'(count_o), 32'd2);
    check("stray_last", 32'(last_prime_o), 32'd3);
    check("stray_err", 32'(err_o), 32'd1);

    // N = 9 from ERR, abort while waiting on cand 5 (with a competing start)
    drop_cand = 4'd5;
    start_scan(4'd9);
    check("ab_err_clr", 32'(err_o), 32'd0);
    check("ab_busy", 32'(busy_o), 32'd1);
    wait_state(ST_WAIT, 4'd5, 40, "ab_reach");
    check("ab_count_pre", 32'(count_o), 32'd2);
    abort_i = 1'b1;
    start_i = 1'b1;
    limit_i = 4'd15;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    base = hs_count;
    check("ab_state", 32'(state_o), 32'(ST_IDLE));
    check("ab_req", 32'(core.req_o), 32'd0);
    check("ab_cand", 32'(core.cand_o), 32'd0);
    check("ab_busy_clr", 32'(busy_o), 32'd0);
    check("ab_done", 32'(done_o), 32'd0);
    check("ab_err", 32'(err_o), 32'd0);
    check("ab_count", 32'(count_o), 32'd0);
    check("ab_last", 32'(last_prime_o), 32'd0);
    tick();
    tick();
    check("ab_idle_hold", 32'(state_o), 32'(ST_IDLE));
    check("ab_no_hs", 32'(hs_count - base), 32'd0);

    drop_en = 1'b0;
    base = hs_count;
    start_scan(4'd2);
    wait_end(20, "n2_end");
    check("n2_done", 32'(done_o), 32'd1);
    check("n2_count", 32'(count_o), 32'd1);
    check("n2_last", 32'(last_prime_o), 32'd2);
    exp_q.push_back(4'd2);
    check_log(base, "n2");

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
